// File: rtl/fifo_arb_pkg.sv
// Purpose: shared FSM state encoding and index-width helper for the FIFO write arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Bits needed to index n items; never less than 1 so a 1-bit port stays legal.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Purpose: round-robin picker; one-hot select of the first req at or after pointer, wrapping.
// Latency: combinational, 0 cycles.
// Backpressure: none; caller gates the select with its own stall conditions.
// Ports: req (request vector), pointer (start index), sel (one-hot pick, zero when no req).
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      pointer,
    output logic [NUM_REQ-1:0] sel
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Walk from pointer upwards; modulo handles non-power-of-two NUM_REQ.
            idx = PW'((int'(pointer) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose: arbitrates NUM_REQ requesters onto one FIFO write port with bursts of up to MAX_BURST beats.
// Latency: 0 cycles; gnt, fifo_wr_en and fifo_data_in are combinational from req/fifo_full.
// Backpressure: fifo_full blocks every grant and freezes state, pointer and beat count.
// Ports: clk/reset (sync, active-high); req/req_data/req_last per requester; gnt one-hot accept;
//        fifo_full/fifo_wr_en/fifo_data_in FIFO side; owner, busy, timeout_err status.
// Optional feature: define FIFO_ARB_TIMEOUT_EN to abort a burst whose owner idles for TIMEOUT cycles.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [WIDTH-1:0]             fifo_data_in,
    output logic [idx_width(NUM_REQ)-1:0] owner,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = idx_width(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LEN = CW'(MAX_BURST);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    arb_state_t         state;
    logic [IW-1:0]      ptr;
    logic [CW-1:0]      beat_cnt;
    logic [NUM_REQ-1:0] rr_sel;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_last;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (IW)
    ) u_pick (
        .req     (req),
        .pointer (ptr),
        .sel     (rr_sel)
    );

    // During a burst only the locked owner is eligible; reset also suppresses grants.
    always_comb begin
        pick = (state == BURST) ? (NUM_REQ'(1) << owner) : rr_sel;
        gnt  = (reset || fifo_full) ? '0 : (pick & req);
    end

    // gnt is one-hot, so the last match is the only match; data stays 0 without a grant.
    always_comb begin
        gnt_idx      = '0;
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx      = IW'(i);
                fifo_data_in = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_wr_en = |gnt;
    assign gnt_last   = |(gnt & req_last);
    assign busy       = (state == BURST);

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int TW = idx_width(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
    logic [TW-1:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            beat_cnt <= '0;
            owner    <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef FIFO_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fifo_wr_en) begin
                        owner <= gnt_idx;
                        if (!gnt_last && MAX_BURST > 1) begin
                            state    <= BURST;
                            beat_cnt <= CW'(1);
                        end else begin
                            ptr <= next_idx(gnt_idx);
                        end
                    end
                end
                BURST: begin
                    if (fifo_wr_en) begin
                        if (gnt_last || (beat_cnt + 1'b1) == BURST_LEN) begin
                            state    <= IDLE;
                            ptr      <= next_idx(owner);
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
`ifdef FIFO_ARB_TIMEOUT_EN
                        to_cnt <= '0;
                    end else if (!fifo_full && !req[owner]) begin
                        // Owner idle while the FIFO could accept: count toward abort.
                        if ((to_cnt + 1'b1) == TO_LIMIT) begin
                            state       <= IDLE;
                            ptr         <= next_idx(owner);
                            beat_cnt    <= '0;
                            to_cnt      <= '0;
                            timeout_err <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose: self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency: outputs sampled mid-cycle (combinational) and 1 time unit after each rising edge (registered).
// Backpressure: fifo_full driven both in directed windows and at random.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 8;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;
    localparam int TIMEOUT   = 8;
`ifdef FIFO_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       gnt;
    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_data_in;
    logic [1:0]               owner;
    logic                     busy;
    logic                     timeout_err;

    fifo_wr_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .owner        (owner),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain integers describing the arbitration rules.
    bit m_busy = 1'b0;
    bit m_terr = 1'b0;
    int m_ptr  = 0;
    int m_owner = 0;
    int m_cnt  = 0;
    int m_to   = 0;

    logic [NUM_REQ-1:0] obs_gnt;
    logic               obs_wr;
    logic               obs_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] model_gnt();
        logic [NUM_REQ-1:0] g;
        int i;
        g = '0;
        if (reset || fifo_full) return g;
        if (m_busy) begin
            if (req[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_ptr + k) % NUM_REQ;
            if (req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_update(input logic [NUM_REQ-1:0] g);
        int i;
        if (reset) begin
            m_busy = 0; m_terr = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_to = 0;
            return;
        end
        m_terr = 0;
        i = 0;
        for (int k = 0; k < NUM_REQ; k++) if (g[k]) i = k;
        if (g != 0) begin
            if (!m_busy) begin
                m_owner = i;
                if (!req_last[i] && MAX_BURST > 1) begin
                    m_busy = 1; m_cnt = 1;
                end else begin
                    m_ptr = (i + 1) % NUM_REQ;
                end
            end else begin
                m_cnt = m_cnt + 1;
                m_to  = 0;
                if (req_last[i] || m_cnt == MAX_BURST) begin
                    m_busy = 0; m_ptr = (m_owner + 1) % NUM_REQ; m_cnt = 0;
                end
            end
        end else if (TO_EN && m_busy && !fifo_full && !req[m_owner]) begin
            m_to = m_to + 1;
            if (m_to == TIMEOUT) begin
                m_busy = 0; m_ptr = (m_owner + 1) % NUM_REQ; m_cnt = 0; m_to = 0; m_terr = 1;
            end
        end
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, clock, check registered outputs.
    task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                        input logic f, input logic rs);
        logic [NUM_REQ-1:0] eg;
        logic [WIDTH-1:0]   ed;
        req       = r;
        req_last  = l;
        fifo_full = f;
        reset     = rs;
        req_data  = $urandom;
        #3;
        eg = model_gnt();
        ed = '0;
        for (int i = 0; i < NUM_REQ; i++) if (eg[i]) ed = req_data[i*WIDTH +: WIDTH];
        chk("gnt", gnt, eg);
        chk("fifo_wr_en", fifo_wr_en, |eg);
        chk("fifo_data_in", fifo_data_in, ed);
        obs_gnt  = gnt;
        obs_wr   = fifo_wr_en;
        obs_busy = busy;
        @(posedge clk);
        model_update(eg);
        #1;
        chk("busy", busy, m_busy);
        chk("owner", owner, m_owner);
        chk("timeout_err", timeout_err, m_terr);
    endtask

    task automatic do_reset();
        step('0, '0, 1'b0, 1'b1);
    endtask

    logic [NUM_REQ-1:0] rr_exp [5];
    logic [NUM_REQ-1:0] bu_exp [5];
    logic               bu_busy [5];

    initial begin
        reset = 1'b1; req = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bu_exp  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        bu_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        @(posedge clk);
        #1;

        // Reset state, with requests present while reset is held.
        do_reset();
        step(4'b1111, 4'b1111, 1'b0, 1'b1);
        chk("rst_gnt", obs_gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 2'd0);
        chk("rst_terr", timeout_err, 1'b0);

        // Single-beat packets rotate round-robin.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b0, 1'b0);
            chk($sformatf("rr_gnt%0d", k), obs_gnt, rr_exp[k]);
        end

        // Requester 2 wants 6 beats; capped at MAX_BURST, then requester 3 served.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b1100, 4'b0000, 1'b0, 1'b0);
            chk($sformatf("burst_gnt%0d", k), obs_gnt, bu_exp[k]);
            chk($sformatf("burst_busy%0d", k), obs_busy, bu_busy[k]);
        end

        // FIFO full mid-burst on requester 1; requester 0 never wins during the lock.
        do_reset();
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        chk("full_b1", obs_gnt, 4'b0010);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        chk("full_b2", obs_gnt, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, 4'b0000, 1'b1, 1'b0);
            chk($sformatf("full_wr%0d", k), obs_wr, 1'b0);
            chk($sformatf("full_busy%0d", k), busy, 1'b1);
        end
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        chk("full_b3", obs_gnt, 4'b0010);
        chk("full_b3_busy", busy, 1'b1);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        chk("full_b4", obs_gnt, 4'b0010);
        chk("full_b4_done", busy, 1'b0);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        chk("full_next", obs_gnt, 4'b0001);

        // Owner 0 goes quiet for TIMEOUT cycles mid-burst.
        do_reset();
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("to_start_busy", busy, 1'b1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(4'b0000, 4'b0000, 1'b0, 1'b0);
            if (k == TIMEOUT - 1) begin
                chk("to_pre_terr", timeout_err, 1'b0);
                chk("to_pre_busy", busy, 1'b1);
            end
        end
`ifdef FIFO_ARB_TIMEOUT_EN
        chk("to_terr", timeout_err, 1'b1);
        chk("to_busy", busy, 1'b0);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        chk("to_ptr", obs_gnt, 4'b0010);
        chk("to_pulse_end", timeout_err, 1'b0);
`else
        chk("to_terr", timeout_err, 1'b0);
        chk("to_busy", busy, 1'b1);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        chk("to_lock", obs_gnt, 4'b0001);
`endif

        // Reset during beat 2 abandons the burst.
        do_reset();
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0100, 4'b0000, 1'b0, 1'b1);
        chk("mid_rst_wr", obs_wr, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_owner", owner, 2'd0);
        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        chk("mid_rst_gnt", obs_gnt, 4'b1000);

        // Pointer wraps from requester 3 back to 0.
        do_reset();
        step(4'b1000, 4'b1111, 1'b0, 1'b0);
        chk("wrap_owner", owner, 2'd3);
        step(4'b1001, 4'b1111, 1'b0, 1'b0);
        chk("wrap_gnt", obs_gnt, 4'b0001);

        // Randomized traffic with varying request density.
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            int dens;
            dens = $urandom_range(5, 90);
            for (int c = 0; c < 200; c++) begin
                logic [NUM_REQ-1:0] r;
                logic [NUM_REQ-1:0] l;
                for (int i = 0; i < NUM_REQ; i++) begin
                    r[i] = ($urandom_range(0, 99) < dens);
                    l[i] = ($urandom_range(0, 3) == 0);
                end
                step(r, l, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
